// File: rtl/mul_writeback_unit.sv
// mul_writeback_unit
//   Iterative shift-add multiplier for LEGv8 MUL / UMULH / SMULH. It sits between
//   the register file read ports (BusA/BusB) and its write port (BusW/RW/RegWr).
//   It retires one multiplier bit per clock and then issues a single-cycle
//   write-back.
//
// Ports
//   Clk    : clock, rising edge
//   Reset  : synchronous, active-high; aborts any operation without a write
//   Start  : request, accepted when idle (or on the edge that leaves WB)
//   Op     : 00 MUL, 01 UMULH, 10 SMULH, 11 MUL
//   BusA   : multiplicand
//   BusB   : multiplier
//   Rd     : destination register index
//   Busy   : high while an operation is in RUN or WB
//   Done   : one-cycle completion pulse
//   RegWr  : register file write enable (never asserted for XZR, Rd == 31)
//   RW     : write register index
//   BusW   : write data
module mul_writeback_unit #(
    parameter int WIDTH = 64,
    parameter int CNTW  = 7
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    input  logic [4:0]       Rd,
    output logic             Busy,
    output logic             Done,
    output logic             RegWr,
    output logic [4:0]       RW,
    output logic [WIDTH-1:0] BusW
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WB
    } stateT;

    stateT              state;
    logic [1:0]         opReg;
    logic [4:0]         rdReg;
    logic [WIDTH-1:0]   mcand;
    // Upper half accumulates partial sums; lower half holds the remaining
    // multiplier bits, consumed from bit 0 as the register shifts right.
    logic [2*WIDTH-1:0] prod;
    logic [CNTW-1:0]    cnt;
    logic               sign;

    logic               isSigned;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prodFinal;
    logic [WIDTH-1:0]   result;
    logic               xzr;

    always_comb begin
        isSigned  = (Op == 2'b10);
        // The most negative value negates to itself, which is exactly its
        // magnitude 2^(WIDTH-1) when read as unsigned.
        absA      = BusA[WIDTH-1] ? ('0 - BusA) : BusA;
        absB      = BusB[WIDTH-1] ? ('0 - BusB) : BusB;
        addend    = prod[0] ? mcand : '0;
        sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        prodFinal = sign ? ('0 - prod) : prod;
        result    = (opReg == 2'b01 || opReg == 2'b10) ? prodFinal[2*WIDTH-1:WIDTH]
                                                       : prodFinal[WIDTH-1:0];
        xzr       = (rdReg == 5'd31);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            opReg <= '0;
            rdReg <= '0;
            mcand <= '0;
            prod  <= '0;
            cnt   <= '0;
            sign  <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            RegWr <= 1'b0;
            RW    <= '0;
            BusW  <= '0;
        end else begin
            Done  <= 1'b0;
            RegWr <= 1'b0;
            RW    <= '0;
            BusW  <= '0;
            case (state)
                // The edge that ends WB samples Start as an idle edge, so a
                // request held high is accepted once every 66 cycles.
                IDLE, WB: begin
                    if (Start) begin
                        state <= RUN;
                        Busy  <= 1'b1;
                        opReg <= Op;
                        rdReg <= Rd;
                        mcand <= isSigned ? absA : BusA;
                        prod  <= {{WIDTH{1'b0}}, (isSigned ? absB : BusB)};
                        sign  <= isSigned & (BusA[WIDTH-1] ^ BusB[WIDTH-1]);
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt == CNTW'(WIDTH)) begin
                        state <= WB;
                        Done  <= 1'b1;
                        BusW  <= result;
                        // RW is suppressed together with RegWr for XZR.
                        RegWr <= ~xzr;
                        RW    <= xzr ? 5'd0 : rdReg;
                    end else begin
                        prod <= {sum, prod[WIDTH-1:1]};
                        cnt  <= cnt + CNTW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_writeback_unit.sv
module tb_mul_writeback_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [63:0] BusA;
    logic [63:0] BusB;
    logic [4:0]  Rd;
    logic        Busy;
    logic        Done;
    logic        RegWr;
    logic [4:0]  RW;
    logic [63:0] BusW;

    int checkCount = 0;
    int errorCount = 0;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULH = 2'b01;
    localparam logic [1:0] OP_SMULH = 2'b10;
    localparam logic [1:0] OP_MUL11 = 2'b11;

    mul_writeback_unit #(.WIDTH(64), .CNTW(7)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .Op    (Op),
        .BusA  (BusA),
        .BusB  (BusB),
        .Rd    (Rd),
        .Busy  (Busy),
        .Done  (Done),
        .RegWr (RegWr),
        .RW    (RW),
        .BusW  (BusW)
    );

    always #5 Clk = ~Clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic scramble();
        BusA = {$urandom, $urandom};
        BusB = {$urandom, $urandom};
        Rd   = 5'($urandom);
        Op   = 2'($urandom);
    endtask

    // Issue one operation and check exact latency and write-back contents.
    task automatic runOp(input string tag, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd,
                         input logic [63:0] expW, input logic expWr, input logic [4:0] expRw);
        @(negedge Clk);
        Start = 1'b1; Op = op; BusA = a; BusB = b; Rd = rd;
        @(posedge Clk);              // E0
        #1;
        Start = 1'b0;
        scramble();
        checkVal({tag, ".busyE0"}, 64'(Busy), 64'd1);
        repeat (64) @(posedge Clk);  // E64
        #1;
        checkVal({tag, ".doneE64"}, 64'(Done), 64'd0);
        @(posedge Clk);              // E65
        #1;
        checkVal({tag, ".done"}, 64'(Done), 64'd1);
        checkVal({tag, ".regwr"}, 64'(RegWr), 64'(expWr));
        checkVal({tag, ".rw"}, 64'(RW), 64'(expRw));
        checkVal({tag, ".busw"}, BusW, expW);
        checkVal({tag, ".busyWb"}, 64'(Busy), 64'd1);
        @(posedge Clk);              // E66
        #1;
        checkVal({tag, ".doneE66"}, 64'(Done), 64'd0);
        checkVal({tag, ".regwrE66"}, 64'(RegWr), 64'd0);
        checkVal({tag, ".buswE66"}, BusW, 64'd0);
        checkVal({tag, ".busyE66"}, 64'(Busy), 64'd0);
    endtask

    initial begin
        int wrPulses;
        Reset = 1'b1; Start = 1'b0; Op = '0; BusA = '0; BusB = '0; Rd = '0;
        repeat (3) @(posedge Clk);
        #1;
        checkVal("rst.busy", 64'(Busy), 64'd0);
        checkVal("rst.done", 64'(Done), 64'd0);
        checkVal("rst.regwr", 64'(RegWr), 64'd0);
        checkVal("rst.rw", 64'(RW), 64'd0);
        checkVal("rst.busw", BusW, 64'd0);
        Reset = 1'b0;

        // Reset mid-RUN at E20, then watch for any stray write.
        @(negedge Clk);
        Start = 1'b1; Op = OP_MUL; BusA = 64'd6; BusB = 64'd7; Rd = 5'd9;
        @(posedge Clk);              // E0
        #1;
        Start = 1'b0;
        repeat (19) @(posedge Clk);  // E19
        #1;
        checkVal("abort.busyE19", 64'(Busy), 64'd1);
        Reset = 1'b1;
        @(posedge Clk);              // E20
        #1;
        Reset = 1'b0;
        checkVal("abort.busy", 64'(Busy), 64'd0);
        wrPulses = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge Clk);
            #1;
            if (RegWr || Done || Busy) wrPulses++;
        end
        checkVal("abort.noWrite", 64'(wrPulses), 64'd0);
        runOp("afterAbort", OP_MUL, 64'd3, 64'd5, 5'd1, 64'd15, 1'b1, 5'd1);

        runOp("mul6x7", OP_MUL, 64'd6, 64'd7, 5'd9, 64'd42, 1'b1, 5'd9);
        runOp("umulhMax", OP_UMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd4, 64'd1, 1'b1, 5'd4);
        runOp("mulMax", OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd4,
              64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 5'd4);
        runOp("smulhNeg1", OP_SMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd3);
        runOp("smulhMinMin", OP_SMULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd5,
              64'h4000_0000_0000_0000, 1'b1, 5'd5);
        runOp("smulhMinOne", OP_SMULH, 64'h8000_0000_0000_0000, 64'd1, 5'd6,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd6);
        runOp("smulhPos", OP_SMULH, 64'd5, 64'd7, 5'd7, 64'd0, 1'b1, 5'd7);
        runOp("umulhBig", OP_UMULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd8,
              64'h4000_0000_0000_0000, 1'b1, 5'd8);
        runOp("mulOp11", OP_MUL11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd10,
              64'hFFFF_FFFF_FFFF_FFF1, 1'b1, 5'd10);
        runOp("mulZero", OP_MUL, 64'd0, 64'd123, 5'd2, 64'd0, 1'b1, 5'd2);
        runOp("xzr", OP_MUL, 64'd6, 64'd7, 5'd31, 64'd42, 1'b0, 5'd0);

        // Start held high: accepted at E0 and again at E66, never inside WB.
        @(negedge Clk);
        Start = 1'b1; Op = OP_MUL; BusA = 64'd10; BusB = 64'd11; Rd = 5'd5;
        @(posedge Clk);              // E0
        #1;
        for (int i = 0; i < 30; i++) begin
            scramble();
            @(posedge Clk);          // E1..E30
            #1;
        end
        Op = OP_MUL; BusA = 64'd100; BusB = 64'd3; Rd = 5'd7;
        repeat (34) @(posedge Clk);  // E64
        #1;
        checkVal("held.doneE64", 64'(Done), 64'd0);
        @(posedge Clk);              // E65
        #1;
        checkVal("held.done1", 64'(Done), 64'd1);
        checkVal("held.busw1", BusW, 64'd110);
        checkVal("held.rw1", 64'(RW), 64'd5);
        @(posedge Clk);              // E66: second request accepted
        #1;
        checkVal("held.busyE66", 64'(Busy), 64'd1);
        checkVal("held.doneE66", 64'(Done), 64'd0);
        scramble();
        repeat (64) @(posedge Clk);  // E130
        #1;
        checkVal("held.doneE130", 64'(Done), 64'd0);
        @(posedge Clk);              // E131
        #1;
        checkVal("held.done2", 64'(Done), 64'd1);
        checkVal("held.busw2", BusW, 64'd300);
        checkVal("held.rw2", 64'(RW), 64'd7);
        Start = 1'b0;
        @(posedge Clk);              // E132
        #1;
        checkVal("held.busyEnd", 64'(Busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
